mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width of internal RAM (2^ADDR_WIDTH 32-bit words).
REQ-002 Parameter LATENCY, default 2, access wait cycles, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 cpu_rst  input  1  reset, synchronous, active-high.
REQ-005 mem_ren  input  1  read request from CPU datapath.
REQ-006 mem_wen  input  1  write request from CPU datapath.
REQ-007 mem_addr  input  32  byte address.
REQ-008 mem_dout  input  32  write data from CPU.
REQ-009 mem_din  output  32  read data to CPU, registered.
REQ-010 mem_stall  output  1  hold-CPU indication; CPU gates cpu_en with ~mem_stall.
REQ-011 mem_err  output  1  registered error flag for the last completed access.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, WAIT, DONE and a 4-bit down-counter cnt.
REQ-013 A request SHALL be present when mem_ren | mem_wen is high.
REQ-014 IDLE: if a request is present, the block SHALL latch op (write if mem_wen, else read), mem_addr and mem_dout, load cnt = LATENCY-1, and go to WAIT; otherwise it SHALL remain in IDLE.
REQ-015 WAIT with cnt != 0: the block SHALL decrement cnt and remain in WAIT.
REQ-016 WAIT with cnt == 0: the block SHALL perform the access at that edge using latched values, update mem_din/mem_err, and go to DONE.
REQ-017 DONE: the block SHALL return unconditionally to IDLE on the next edge; the CPU advances on that same edge.
REQ-018 mem_stall SHALL be combinational: 1 in IDLE with a request present, 1 in WAIT, 0 in DONE, and 0 in IDLE without a request.
REQ-019 A memory instruction SHALL therefore see exactly LATENCY+1 stalled cycles followed by one DONE cycle.
REQ-020 A read access SHALL load mem_din with RAM[addr[ADDR_WIDTH+1:2]].
REQ-021 A write access SHALL write the latched data to RAM and SHALL leave mem_din unchanged.
REQ-022 mem_din and mem_err SHALL hold their value until the next completed access.
REQ-023 Error condition: the access SHALL be flagged as an error when latched addr[1:0] != 0 or addr[31:ADDR_WIDTH+2] != 0.
REQ-024 On an error access, the block SHALL set mem_err=1, perform no RAM write, and load mem_din with 0 for reads; the access SHALL still complete with normal latency.
REQ-025 Simultaneous mem_ren & mem_wen SHALL be treated as a write with mem_err=1; the write SHALL still be performed if the address is valid.
REQ-026 Request withdrawn in WAIT (mem_ren=mem_wen=0): the block SHALL abort to IDLE with no RAM write, and mem_din/mem_err SHALL be unchanged.
REQ-027 Changes to mem_addr, mem_dout or op while in WAIT SHALL be ignored; the latched values apply.
REQ-028 A non-error access SHALL clear mem_err to 0.

Reset
REQ-029 When cpu_rst=1 at an edge, the block SHALL set state=IDLE, cnt=0, mem_din=0 and mem_err=0.
REQ-030 While cpu_rst=1, mem_stall SHALL be forced to 0.
REQ-031 Reset mid-access (in WAIT or DONE) SHALL cancel the access with no RAM write.
REQ-032 RAM contents SHALL NOT be cleared by reset.

Verification (LATENCY=2, ADDR_WIDTH=8)
REQ-033 Write 0xDEADBEEF to 0x10, then read 0x10 -> mem_stall high for 3 cycles on each access; mem_din=0xDEADBEEF in the read's DONE cycle; mem_err=0.
REQ-034 Read 0x12 (misaligned) -> normal latency; mem_din=0; mem_err=1; the next valid read clears mem_err.
REQ-035 Write 0x5 to 0x400 (out of range) -> mem_err=1; a subsequent read of 0x0 returns its prior value unchanged.
REQ-036 mem_ren and mem_wen both high, data 0xA5A5A5A5, address 0x20 -> mem_err=1; a later read of 0x20 returns 0xA5A5A5A5.
REQ-037 Start a write, then drop mem_wen in the first WAIT cycle -> FSM returns to IDLE; RAM word unchanged.
REQ-038 Start a write, then assert cpu_rst in WAIT -> outputs reset to 0, no write; RAM data written before the reset survives.
REQ-039 Back-to-back reads at 0x0 and 0x4 -> the IDLE cycle after DONE stalls immediately; each mem_din value is correct in its DONE cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: stalls the CPU for LATENCY+1 cycles per access
// and serves reads/writes from an internal word-addressed RAM.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;

  logic [1:0]  state_q;
  logic [3:0]  cnt_q;
  logic        op_wr_q;
  logic        op_both_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic [31:0] ram [DEPTH];

  logic                  req;
  logic                  addr_bad;
  logic                  fire;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign req      = mem_ren | mem_wen;
  assign addr_bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  // The access only completes if the CPU is still requesting in the last wait cycle.
  assign fire     = (state_q == WAIT) && req && (cnt_q == 4'd0);
  assign ram_we   = fire && op_wr_q && !addr_bad && !cpu_rst;

  always_comb begin
    mem_stall = 1'b0;
    if (!cpu_rst) begin
      case (state_q)
        IDLE:    mem_stall = req;
        WAIT:    mem_stall = 1'b1;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  // RAM has no reset so its contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[word_idx] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mem_din <= 32'd0;
      mem_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            op_wr_q   <= mem_wen;
            op_both_q <= mem_ren & mem_wen;
            addr_q    <= mem_addr;
            data_q    <= mem_dout;
            cnt_q     <= CNT_LOAD;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (op_wr_q) begin
              mem_err <= addr_bad || op_both_q;
            end else begin
              mem_err <= addr_bad;
              mem_din <= addr_bad ? 32'd0 : ram[word_idx];
            end
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder checked against a word-array memory model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_dout = 32'd0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [31:0] mdl_mem [256];
  logic [31:0] exp_din = 32'd0;
  logic        exp_err = 1'b0;

  typedef struct {
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  mem_responder #(
    .ADDR_WIDTH(8),
    .LATENCY   (2)
  ) dut (
    .clk      (clk),
    .cpu_rst  (cpu_rst),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_stall(mem_stall),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Memory of 256 words; anything unaligned or at/after byte 1024 is an error.
  function automatic void model_access(input bit ren, input bit wen, input logic [31:0] addr,
                                       input logic [31:0] data);
    bit bad;
    bad = (addr % 4 != 0) || (addr >= 32'd1024);
    if (wen) begin
      if (!bad) mdl_mem[addr / 4] = data;
      exp_err = bad || ren;
    end else begin
      exp_din = bad ? 32'd0 : mdl_mem[addr / 4];
      exp_err = bad;
    end
  endfunction

  // Drives one access until the first non-stalled cycle; returns the observed results.
  task automatic do_access(input bit ren, input bit wen, input logic [31:0] addr,
                           input logic [31:0] data, input bit scramble, output int stalls,
                           output logic [31:0] din, output logic err);
    @(negedge clk);
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = data;
    stalls   = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!mem_stall) break;
      stalls++;
      @(negedge clk);
      if (scramble) begin
        mem_addr = $urandom;
        mem_dout = $urandom;
        mem_ren  = 1'b1;
        mem_wen  = 1'($urandom_range(0, 1));
      end
    end
    din = mem_din;
    err = mem_err;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall);
    else passed++;
    checks++;
    if (mem_din !== 32'd0) $display("FAIL reset_din: got %h want 0", mem_din);
    else passed++;
    checks++;
    if (mem_err !== 1'b0) $display("FAIL reset_err: got %b want 0", mem_err);
    else passed++;
    @(negedge clk);
    cpu_rst = 1'b0;
    mem_wen = 1'b0;
    exp_din = 32'd0;
    exp_err = 1'b0;
  endtask

  task automatic test_init();
    int st; logic [31:0] d; logic e; logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      do_access(1'b0, 1'b1, 32'(i * 4), v, 1'b0, st, d, e);
      model_access(1'b0, 1'b1, 32'(i * 4), v);
      checks++;
      if (st !== 3) $display("FAIL init_stalls[%0d]: got %0d want 3", i, st);
      else passed++;
      checks++;
      if (e !== exp_err || d !== exp_din)
        $display("FAIL init_out[%0d]: got din=%h err=%b want din=%h err=%b", i, d, e, exp_din,
                 exp_err);
      else passed++;
    end
  endtask

  task automatic test_directed();
    op_t tbl [8];
    int st; logic [31:0] d; logic e;
    tbl[0] = '{0, 1, 32'h10,  32'hDEADBEEF};
    tbl[1] = '{1, 0, 32'h10,  32'h0};
    tbl[2] = '{1, 0, 32'h12,  32'h0};
    tbl[3] = '{1, 0, 32'h14,  32'h0};
    tbl[4] = '{0, 1, 32'h400, 32'h5};
    tbl[5] = '{1, 0, 32'h0,   32'h0};
    tbl[6] = '{1, 1, 32'h20,  32'hA5A5A5A5};
    tbl[7] = '{1, 0, 32'h20,  32'h0};
    foreach (tbl[i]) begin
      do_access(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].data, 1'b0, st, d, e);
      model_access(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].data);
      checks++;
      if (st !== 3) $display("FAIL dir_stalls[%0d]: got %0d want 3", i, st);
      else passed++;
      checks++;
      if (d !== exp_din) $display("FAIL dir_din[%0d]: got %h want %h", i, d, exp_din);
      else passed++;
      checks++;
      if (e !== exp_err) $display("FAIL dir_err[%0d]: got %b want %b", i, e, exp_err);
      else passed++;
    end
  endtask

  task automatic test_abort();
    int st; logic [31:0] d; logic e;
    @(negedge clk);
    mem_wen  = 1'b1;
    mem_addr = 32'h8;
    mem_dout = 32'h12345678;
    #1;
    checks++;
    if (mem_stall !== 1'b1) $display("FAIL abort_idle_stall: got %b want 1", mem_stall);
    else passed++;
    @(negedge clk);
    mem_wen = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b1) $display("FAIL abort_wait_stall: got %b want 1", mem_stall);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (mem_stall !== 1'b0 || mem_din !== exp_din || mem_err !== exp_err)
      $display("FAIL abort_after: got stall=%b din=%h err=%b want stall=0 din=%h err=%b",
               mem_stall, mem_din, mem_err, exp_din, exp_err);
    else passed++;
    do_access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, st, d, e);
    model_access(1'b1, 1'b0, 32'h8, 32'h0);
    checks++;
    if (d !== exp_din) $display("FAIL abort_ram: got %h want %h", d, exp_din);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] d; logic e;
    @(negedge clk);
    mem_wen  = 1'b1;
    mem_addr = 32'hC;
    mem_dout = 32'hCAFEF00D;
    @(negedge clk);
    cpu_rst = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", mem_stall);
    else passed++;
    @(negedge clk);
    cpu_rst = 1'b0;
    mem_wen = 1'b0;
    #1;
    checks++;
    if (mem_din !== 32'd0 || mem_err !== 1'b0 || mem_stall !== 1'b0)
      $display("FAIL rstmid_out: got din=%h err=%b stall=%b want 0/0/0", mem_din, mem_err,
               mem_stall);
    else passed++;
    exp_din = 32'd0;
    exp_err = 1'b0;
    do_access(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, st, d, e);
    model_access(1'b1, 1'b0, 32'hC, 32'h0);
    checks++;
    if (d !== exp_din) $display("FAIL rstmid_ram: got %h want %h", d, exp_din);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] d; logic e;
    for (int i = 0; i < 2; i++) begin
      do_access(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, st, d, e);
      model_access(1'b1, 1'b0, 32'(i * 4), 32'h0);
      checks++;
      if (st !== 3) $display("FAIL b2b_stalls[%0d]: got %0d want 3", i, st);
      else passed++;
      checks++;
      if (d !== exp_din || e !== exp_err)
        $display("FAIL b2b_out[%0d]: got din=%h err=%b want din=%h err=%b", i, d, e, exp_din,
                 exp_err);
      else passed++;
    end
  endtask

  task automatic test_random();
    int st; logic [31:0] d; logic e;
    bit ren, wen, scr;
    logic [31:0] addr, data;
    for (int i = 0; i < 60; i++) begin
      addr = 32'($urandom_range(0, 15) * 4);
      data = $urandom;
      ren  = 1'b1;
      wen  = 1'b0;
      case ($urandom_range(0, 5))
        0, 1: ;
        2: begin ren = 1'b0; wen = 1'b1; end
        3: begin addr = addr + 32'($urandom_range(1, 3)); wen = 1'($urandom_range(0, 1));
                 ren = !wen; end
        4: begin addr = addr | (32'h1 << $urandom_range(10, 31)); wen = 1'($urandom_range(0, 1));
                 ren = !wen; end
        default: wen = 1'b1;
      endcase
      scr = 1'($urandom_range(0, 1));
      do_access(ren, wen, addr, data, scr, st, d, e);
      model_access(ren, wen, addr, data);
      checks++;
      if (st !== 3) $display("FAIL rnd_stalls[%0d]: got %0d want 3", i, st);
      else passed++;
      checks++;
      if (d !== exp_din || e !== exp_err)
        $display("FAIL rnd_out[%0d] addr=%h r=%b w=%b: got din=%h err=%b want din=%h err=%b",
                 i, addr, ren, wen, d, e, exp_din, exp_err);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
